// File: rtl/mv_window_ctrl_if.sv
// Handshake/bus bundle between the moving-window controller and its environment.
// Latency: none (plain signal bundle).
// Backpressure: carries iStall from downstream; the controller freezes progress while it is high.
interface mv_window_ctrl_if #(
    parameter int WIN_ROWS = 5,
    parameter int ADDR_W   = 13
);
    logic                iRun_MV;
    logic                iAbort;
    logic                iStall;
    logic [WIN_ROWS-1:0] iFF_full;
    logic                iSum_finish;
    logic                oRun_sum;
    logic                oRst_reg;
    logic [WIN_ROWS-1:0] oRdreq_FF;
    logic [WIN_ROWS-1:0] oWrreq_FF;
    logic                oRd_OM;
    logic [ADDR_W-1:0]   oAddr_OM;
    logic [ADDR_W-1:0]   oPosition;
    logic                oOutput_ready;
    logic                oBusy;
    logic                oErr;
    logic [15:0]         oStall_cnt;

    // Controller side
    modport slave (
        input  iRun_MV, iAbort, iStall, iFF_full, iSum_finish,
        output oRun_sum, oRst_reg, oRdreq_FF, oWrreq_FF, oRd_OM, oAddr_OM,
        output oPosition, oOutput_ready, oBusy, oErr, oStall_cnt
    );

    // Environment side
    modport master (
        output iRun_MV, iAbort, iStall, iFF_full, iSum_finish,
        input  oRun_sum, oRst_reg, oRdreq_FF, oWrreq_FF, oRd_OM, oAddr_OM,
        input  oPosition, oOutput_ready, oBusy, oErr, oStall_cnt
    );
endinterface

// File: rtl/mv_window_ctrl.sv
// Moving-window controller: streams the OM frame into a WIN_ROWS line-FIFO cascade, starts the sum engine, tracks window position.
// Latency: OM read -> FIFO write 1 cycle; last-row FIFO read -> oRun_sum 1 cycle; oPosition == OUT_READY_VAL -> oOutput_ready 1 cycle.
// Backpressure: iStall freezes address, pixel counter and read-valid and zeroes all requests for that cycle; oPosition still follows iSum_finish.
// Optional feature macro MV_STALL_CNT_EN: enables the 16-bit saturating stall-cycle counter on oStall_cnt.
module mv_window_ctrl #(
    parameter int IMG_W         = 80,
    parameter int IMG_H         = 60,
    parameter int WIN_ROWS      = 5,
    parameter int ADDR_W        = 13,
    parameter int OUT_READY_VAL = IMG_W * IMG_H
) (
    input  logic            iClk,
    input  logic            iReset_n,
    mv_window_ctrl_if.slave bus
);
    localparam int unsigned       PIX_TOTAL = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_TOTAL - 1);
    localparam logic [ADDR_W-1:0] POS_MAX   = '1;
    localparam logic [ADDR_W-1:0] DONE_POS  = ADDR_W'(OUT_READY_VAL);
    localparam logic [ADDR_W:0]   STRIDE    = (ADDR_W + 1)'(WIN_ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_om_done;
    logic                r_pix_v;
    logic [15:0]         r_pix_cnt;
    logic [WIN_ROWS-1:0] r_rd_en;
    logic                r_run_sum;
    logic [ADDR_W-1:0]   r_pos;
    logic                r_fin_d;
    logic                r_err;

    logic                w_active;
    logic                w_adv;
    logic                w_start;
    logic                w_abort;
    logic                w_rd_om;
    logic                w_pix_v;
    logic [WIN_ROWS-1:0] w_set;
    logic [WIN_ROWS-1:0] w_wrreq;
    logic [WIN_ROWS-1:0] w_rdreq;
    logic                w_fin;
    logic                w_fall;
    logic [ADDR_W:0]     w_pos_inc;
    logic [ADDR_W:0]     w_pos_sum;
    logic [ADDR_W-1:0]   w_pos_nxt;

    assign w_active = (r_state == S_FILL) || (r_state == S_RUN);
    assign w_adv    = w_active & ~bus.iStall;
    assign w_start  = (r_state == S_IDLE) & bus.iRun_MV;
    assign w_abort  = bus.iAbort & (r_state != S_IDLE);
    // The read valid is held through a stall and only consumed on an advancing cycle.
    assign w_rd_om  = w_adv & ~r_om_done;
    assign w_pix_v  = r_pix_v & w_adv;

    // Row k becomes readable once the pixel counter reaches (k+1) full lines.
    always_comb begin
        w_set = '0;
        for (int k = 0; k < WIN_ROWS; k++) begin
            if (w_pix_v && ((r_pix_cnt + 16'd1) == 16'((k + 1) * IMG_W))) begin
                w_set[k] = 1'b1;
            end
        end
    end

    // Each FIFO is written while the row above it is being drained: a row cascade.
    assign w_wrreq = {r_rd_en[WIN_ROWS-2:0], 1'b1} & {WIN_ROWS{w_pix_v}};
    assign w_rdreq = r_rd_en & {WIN_ROWS{w_pix_v}};

    assign w_fin     = bus.iSum_finish & (r_state == S_RUN);
    assign w_fall    = ~bus.iSum_finish & r_fin_d & (r_state == S_RUN);
    assign w_pos_inc = w_fin ? (ADDR_W + 1)'(1) : (w_fall ? STRIDE : '0);
    assign w_pos_sum = {1'b0, r_pos} + w_pos_inc;
    assign w_pos_nxt = (w_pos_sum > {1'b0, POS_MAX}) ? POS_MAX : w_pos_sum[ADDR_W-1:0];

    // State register
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.iRun_MV) w_state_nxt = S_FILL;
            S_FILL: if (w_set[WIN_ROWS-1]) w_state_nxt = S_RUN;
            S_RUN:  if (r_pos == DONE_POS) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    // OM address walk and one-cycle-latency read valid
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_addr    <= '0;
            r_om_done <= 1'b0;
            r_pix_v   <= 1'b0;
        end else if (w_start) begin
            r_addr    <= '0;
            r_om_done <= 1'b0;
            r_pix_v   <= 1'b0;
        end else if (w_abort) begin
            r_pix_v   <= 1'b0;
        end else if (w_adv) begin
            r_pix_v <= w_rd_om;
            if (w_rd_om) begin
                if (r_addr == LAST_ADDR) r_om_done <= 1'b1;
                else                     r_addr    <= r_addr + 1'b1;
            end
        end
    end

    // Pixel counter and sticky per-row read enables
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_pix_cnt <= '0;
            r_rd_en   <= '0;
        end else if (r_state == S_IDLE) begin
            r_rd_en <= '0;
            if (bus.iRun_MV) r_pix_cnt <= '0;
        end else if (w_pix_v) begin
            r_pix_cnt <= r_pix_cnt + 16'd1;
            r_rd_en   <= r_rd_en | w_set;
        end
    end

    // Sum engine runs one cycle behind the last-row FIFO read
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) r_run_sum <= 1'b0;
        else           r_run_sum <= w_rdreq[WIN_ROWS-1];
    end

    // Window position: +1 per finished column, +WIN_ROWS-1 at end of row
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_pos   <= '0;
            r_fin_d <= 1'b0;
        end else if (w_start) begin
            r_pos   <= '0;
            r_fin_d <= 1'b0;
        end else begin
            r_pos   <= w_pos_nxt;
            r_fin_d <= w_fin;
        end
    end

    // Sticky overflow flag, cleared only by an accepted start
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n)                       r_err <= 1'b0;
        else if (w_start)                    r_err <= 1'b0;
        else if (|(w_wrreq & bus.iFF_full))  r_err <= 1'b1;
    end

`ifdef MV_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of stalled FILL/RUN cycles
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n)                                            r_stall_cnt <= '0;
        else if (w_start)                                         r_stall_cnt <= '0;
        else if (w_active && bus.iStall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign bus.oStall_cnt = r_stall_cnt;
`else
    assign bus.oStall_cnt = 16'd0;
`endif

    assign bus.oRd_OM        = w_rd_om;
    assign bus.oAddr_OM      = r_addr;
    assign bus.oWrreq_FF     = w_wrreq;
    assign bus.oRdreq_FF     = w_rdreq;
    assign bus.oRun_sum      = r_run_sum & (r_state == S_RUN);
    assign bus.oPosition     = r_pos;
    assign bus.oOutput_ready = (r_state == S_DONE);
    assign bus.oRst_reg      = (r_state == S_DONE);
    assign bus.oBusy         = (r_state != S_IDLE);
    assign bus.oErr          = r_err;
endmodule

// File: tb/tb_mv_window_ctrl.sv
`timescale 1ns/1ps
module tb_mv_window_ctrl;
    logic iClk = 1'b0;
    logic iReset_n = 1'b0;
    always #5 iClk = ~iClk;

    mv_window_ctrl_if #(.WIN_ROWS(5), .ADDR_W(13)) bus_a ();
    mv_window_ctrl_if #(.WIN_ROWS(3), .ADDR_W(8))  bus_b ();

    mv_window_ctrl #(.IMG_W(80), .IMG_H(60), .WIN_ROWS(5), .ADDR_W(13), .OUT_READY_VAL(4800)) dut_a (
        .iClk(iClk), .iReset_n(iReset_n), .bus(bus_a));
    mv_window_ctrl #(.IMG_W(16), .IMG_H(8), .WIN_ROWS(3), .ADDR_W(8), .OUT_READY_VAL(128)) dut_b (
        .iClk(iClk), .iReset_n(iReset_n), .bus(bus_b));

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int c0;
    int mpos;
    bit mprev;

    // expected OM address streams
    int q_a[$];
    int q_b[$];

    int wr_a, first_rd0_a, first_rd4_a, t_rd4_a, done_a, rst_a, t_done_a, last_addr_a;
    int wr_b, first_rd2_b, t_rd2_b, done_b, last_addr_b;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    always @(posedge iClk) cyc <= cyc + 1;

    // monitor A: pop expected addresses, track first row reads and done pulses
    always @(negedge iClk) begin
        if (bus_a.oRd_OM) begin
            last_addr_a = int'(bus_a.oAddr_OM);
            if (q_a.size() == 0) check("a_om_addr_unexpected", bus_a.oAddr_OM, -1);
            else check("a_om_addr", bus_a.oAddr_OM, q_a.pop_front());
        end
        if (bus_a.oRdreq_FF[0] && first_rd0_a < 0) first_rd0_a = wr_a;
        if (bus_a.oRdreq_FF[4] && first_rd4_a < 0) begin first_rd4_a = wr_a; t_rd4_a = cyc; end
        if (bus_a.oWrreq_FF[0]) wr_a++;
        if (bus_a.oOutput_ready) begin done_a++; t_done_a = cyc; end
        if (bus_a.oRst_reg) rst_a++;
    end

    // monitor B
    always @(negedge iClk) begin
        if (bus_b.oRd_OM) begin
            last_addr_b = int'(bus_b.oAddr_OM);
            if (q_b.size() == 0) check("b_om_addr_unexpected", bus_b.oAddr_OM, -1);
            else check("b_om_addr", bus_b.oAddr_OM, q_b.pop_front());
        end
        if (bus_b.oRdreq_FF[2] && first_rd2_b < 0) begin first_rd2_b = wr_b; t_rd2_b = cyc; end
        if (bus_b.oWrreq_FF[0]) wr_b++;
        if (bus_b.oOutput_ready) done_b++;
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    function automatic int pos_of(input bit s);
        return s ? int'(bus_b.oPosition) : int'(bus_a.oPosition);
    endfunction

    task automatic set_fin(input bit s, input bit f);
        if (s) bus_b.iSum_finish = f;
        else   bus_a.iSum_finish = f;
    endtask

    task automatic start_run(input bit s);
        tick();
        c0 = cyc;
        mpos = 0;
        mprev = 1'b0;
        if (s) begin
            wr_b = 0; first_rd2_b = -1; done_b = 0;
            q_b.delete();
            for (int a = 0; a < 128; a++) q_b.push_back(a);
            bus_b.iRun_MV = 1'b1;
        end else begin
            wr_a = 0; first_rd0_a = -1; first_rd4_a = -1; done_a = 0; rst_a = 0;
            q_a.delete();
            for (int a = 0; a < 4800; a++) q_a.push_back(a);
            bus_a.iRun_MV = 1'b1;
        end
        tick();
        bus_a.iRun_MV = 1'b0;
        bus_b.iRun_MV = 1'b0;
    endtask

    task automatic wait_top(input bit s, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            got = s ? (first_rd2_b >= 0) : (first_rd4_a >= 0);
        end
        check("wait_top_row_read", got, 1);
    endtask

    task automatic wait_idle(input bit s, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            got = s ? !bus_b.oBusy : !bus_a.oBusy;
        end
        check("wait_idle", got, 1);
    endtask

    task automatic wait_wr2(input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            got = bus_a.oWrreq_FF[2];
        end
        check("wait_wrreq2", got, 1);
    endtask

    // rows of hi finish pulses then lo idle cycles, then 'extra' more high cycles
    task automatic drive_fin(input bit s, input int rows, input int hi, input int lo,
                             input int stride, input int extra);
        int body;
        int c;
        bit f;
        body = rows * (hi + lo);
        for (int i = 0; i < body + extra; i++) begin
            c = (i < body) ? (i % (hi + lo)) : -1;
            f = (i >= body) ? 1'b1 : (c < hi);
            tick();
            if (c == 0 && i > 0) check("pos_row_end", pos_of(s), mpos);
            if (c == hi)         check("pos_row_hi", pos_of(s), mpos);
            set_fin(s, f);
            if (f) mpos = mpos + 1;
            else if (mprev) mpos = mpos + stride;
            mprev = f;
        end
        tick();
        check("pos_final", pos_of(s), mpos);
        set_fin(s, 1'b0);
        if (mprev) mpos = mpos + stride;
        mprev = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_done1;
        int a0;
        int w0;
        int d0;
        bus_a.iRun_MV = 0; bus_a.iAbort = 0; bus_a.iStall = 0; bus_a.iFF_full = '0; bus_a.iSum_finish = 0;
        bus_b.iRun_MV = 0; bus_b.iAbort = 0; bus_b.iStall = 0; bus_b.iFF_full = '0; bus_b.iSum_finish = 0;
        wr_a = 0; first_rd0_a = -1; first_rd4_a = -1; done_a = 0; rst_a = 0; last_addr_a = -1;
        wr_b = 0; first_rd2_b = -1; done_b = 0; last_addr_b = -1;

        // reset state
        #3;
        check("rst_busy", bus_a.oBusy, 0);
        check("rst_addr", bus_a.oAddr_OM, 0);
        check("rst_pos", bus_a.oPosition, 0);
        check("rst_err", bus_a.oErr, 0);
        check("rst_rd_om", bus_a.oRd_OM, 0);
        check("rst_out_ready", bus_a.oOutput_ready, 0);
        check("rst_wrreq", bus_a.oWrreq_FF, 0);
        check("rst_rdreq", bus_a.oRdreq_FF, 0);
        check("rst_run_sum", bus_a.oRun_sum, 0);
        check("rst_stall_cnt", bus_a.oStall_cnt, 0);
        tick();
        iReset_n = 1'b1;
        tick();

        // full frame, no stall
        start_run(0);
        wait_top(0, 1000);
        check("t1_first_rd0_writes", first_rd0_a, 80);
        check("t1_first_rd4_writes", first_rd4_a, 400);
        check("t1_rd4_latency", t_rd4_a - c0, 402);
        drive_fin(0, 60, 76, 4, 4, 0);
        wait_idle(0, 50);
        check("t1_done_pulses", done_a, 1);
        check("t1_rst_reg_pulses", rst_a, 1);
        check("t1_last_addr", last_addr_a, 4799);
        check("t1_addr_left", q_a.size(), 0);
        check("t1_err", bus_a.oErr, 0);
        check("t1_stall_cnt", bus_a.oStall_cnt, 0);
        lat_done1 = t_done_a - c0;

        // 10-cycle stall mid-FILL
        start_run(0);
        repeat (100) tick();
        a0 = int'(bus_a.oAddr_OM);
        w0 = wr_a;
        bus_a.iStall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("t3_addr_frozen", bus_a.oAddr_OM, a0);
            check("t3_rd_om", bus_a.oRd_OM, 0);
            check("t3_wrreq", bus_a.oWrreq_FF, 0);
            check("t3_rdreq", bus_a.oRdreq_FF, 0);
            tick();
        end
        bus_a.iStall = 1'b0;
        check("t3_pix_frozen", wr_a, w0);
        wait_top(0, 1000);
        check("t3_rd4_latency", t_rd4_a - c0, 412);
        drive_fin(0, 60, 76, 4, 4, 0);
        wait_idle(0, 50);
        check("t3_done_pulses", done_a, 1);
        check("t3_done_delay", (t_done_a - c0) - lat_done1, 10);
`ifdef MV_STALL_CNT_EN
        check("t3_stall_cnt", bus_a.oStall_cnt, 10);
`else
        check("t3_stall_cnt", bus_a.oStall_cnt, 0);
`endif

        // abort in RUN at position 1000
        start_run(0);
        wait_top(0, 1000);
        drive_fin(0, 12, 76, 4, 4, 40);
        check("t4_pos_1000", bus_a.oPosition, 1000);
        d0 = done_a;
        bus_a.iAbort = 1'b1;
        tick();
        bus_a.iAbort = 1'b0;
        #1;
        check("t4_busy", bus_a.oBusy, 0);
        check("t4_rd_om", bus_a.oRd_OM, 0);
        check("t4_wrreq", bus_a.oWrreq_FF, 0);
        check("t4_rdreq", bus_a.oRdreq_FF, 0);
        check("t4_out_ready", bus_a.oOutput_ready, 0);
        q_a.delete();
        repeat (5) tick();
        check("t4_no_done", done_a, d0);
        start_run(0);
        check("t4_restart_addr", bus_a.oAddr_OM, 0);
        check("t4_restart_rd_om", bus_a.oRd_OM, 1);

        // overflow on FIFO 2
        wait_wr2(1000);
        check("t5_err_before", bus_a.oErr, 0);
        bus_a.iFF_full = 5'b00100;
        tick();
        bus_a.iFF_full = '0;
        check("t5_err_set", bus_a.oErr, 1);
        wait_top(0, 1000);
        drive_fin(0, 60, 76, 4, 4, 0);
        wait_idle(0, 50);
        check("t5_done_pulses", done_a, 1);
        check("t5_err_after_done", bus_a.oErr, 1);
        start_run(0);
        #1;
        check("t5_err_cleared", bus_a.oErr, 0);

        // async reset mid-RUN
        wait_top(0, 1000);
        drive_fin(0, 2, 76, 4, 4, 0);
        wait_wr2(100);
        bus_a.iFF_full = 5'b00100;
        tick();
        bus_a.iFF_full = '0;
        check("t6_err_pre", bus_a.oErr, 1);
        check("t6_busy_pre", bus_a.oBusy, 1);
        check("t6_pos_pre", bus_a.oPosition, 160);
        #1;
        iReset_n = 1'b0;
        #1;
        check("t6_busy", bus_a.oBusy, 0);
        check("t6_addr", bus_a.oAddr_OM, 0);
        check("t6_pos", bus_a.oPosition, 0);
        check("t6_err", bus_a.oErr, 0);
        check("t6_rd_om", bus_a.oRd_OM, 0);
        check("t6_wrreq", bus_a.oWrreq_FF, 0);
        check("t6_rdreq", bus_a.oRdreq_FF, 0);
        check("t6_run_sum", bus_a.oRun_sum, 0);
        tick();
        iReset_n = 1'b1;
        q_a.delete();

        // small frame: 16x8, 3-row window
        start_run(1);
        wait_top(1, 300);
        check("t6b_first_rd2_writes", first_rd2_b, 48);
        check("t6b_rd2_latency", t_rd2_b - c0, 50);
        drive_fin(1, 8, 14, 2, 2, 0);
        wait_idle(1, 50);
        check("t6b_done_pulses", done_b, 1);
        check("t6b_last_addr", last_addr_b, 127);
        check("t6b_addr_left", q_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
